// File: rtl/uart_reg_responder.sv
// Byte-level register read/write responder behind a UART: decodes 'W' addr data / 'R' addr
// frames, drives a simple register bus and returns ACK, NAK or read data via the transmitter.
module uart_reg_responder #(
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned NUM_REGS      = 12,
    parameter int unsigned TIMEOUT_TICKS = 640,
    parameter logic [7:0]  ACK_BYTE      = 8'h06,
    parameter logic [7:0]  NAK_BYTE      = 8'h15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud16_en,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_error,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic [7:0]        err_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_DO_WR,
        S_DO_RD,
        S_RD_CAP,
        S_NAK,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);
    localparam logic [7:0]       CMD_WR   = 8'h57;
    localparam logic [7:0]       CMD_RD   = 8'h52;

    state_t            r_state;
    state_t            w_next;
    logic              r_cmd_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_tx_data;
    logic [7:0]        r_err_count;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              w_in_frame;
    logic              w_timeout;
    logic              w_addr_ok;
    logic              w_cmd_ok;
    logic              w_err_inc;

    assign w_in_frame = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    // A byte arriving on the expiry tick wins over the timeout.
    assign w_timeout  = w_in_frame && baud16_en && !rx_ready && (r_tmo_cnt == TMO_LAST);
    assign w_addr_ok  = !rx_error && ({1'b0, rx_data} < 9'(NUM_REGS));
    assign w_cmd_ok   = !rx_error && ((rx_data == CMD_WR) || (rx_data == CMD_RD));
    assign w_err_inc  = (r_state == S_NAK) || w_timeout;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_next   = r_state;
        tx_start = 1'b0;
        case (r_state)
            S_IDLE:     if (rx_ready) w_next = w_cmd_ok ? S_GET_ADDR : S_NAK;
            S_GET_ADDR: begin
                if (rx_ready)       w_next = !w_addr_ok ? S_NAK : (r_cmd_wr ? S_GET_DATA : S_DO_RD);
                else if (w_timeout) w_next = S_IDLE;
            end
            S_GET_DATA: begin
                if (rx_ready)       w_next = rx_error ? S_NAK : S_DO_WR;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_DO_WR:    w_next = S_SEND;
            S_DO_RD:    w_next = S_RD_CAP;
            S_RD_CAP:   w_next = S_SEND;
            S_NAK:      w_next = S_SEND;
            S_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    w_next   = S_WAIT_HI;
                end
            end
            S_WAIT_HI:  if (tx_busy)  w_next = S_WAIT_LO;
            S_WAIT_LO:  if (!tx_busy) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd_wr    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_tx_data   <= '0;
            r_err_count <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_next;
            if (r_state == S_IDLE && rx_ready)
                r_cmd_wr <= (rx_data == CMD_WR);
            if (r_state == S_GET_ADDR && rx_ready && w_addr_ok)
                r_addr <= rx_data[ADDR_W-1:0];
            if (r_state == S_GET_DATA && rx_ready && !rx_error)
                r_wdata <= rx_data;

            case (r_state)
                S_DO_WR:  r_tx_data <= ACK_BYTE;
                S_RD_CAP: r_tx_data <= reg_rdata;
                S_NAK:    r_tx_data <= NAK_BYTE;
                default:  r_tx_data <= r_tx_data;
            endcase

            if (w_err_inc && (r_err_count != 8'hFF))
                r_err_count <= r_err_count + 8'd1;

            // Inter-byte timer only runs while a frame is partially received.
            if (!w_in_frame || rx_ready)
                r_tmo_cnt <= '0;
            else if (baud16_en)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign tx_data   = r_tx_data;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_wr    = (r_state == S_DO_WR);
    assign reg_rd    = (r_state == S_DO_RD);
    assign busy      = (r_state != S_IDLE);
    assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Randomized bench for uart_reg_responder: a frame-level protocol model predicts replies,
// register writes and error counts; bus slave and transmitter are modelled around the DUT.
module tb_uart_reg_responder;

    localparam int NUM_REGS      = 12;
    localparam int TIMEOUT_TICKS = 640;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud16_en = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       rx_error = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic [7:0] err_count;

    uart_reg_responder dut (
        .clk       (clk),
        .rst       (rst),
        .baud16_en (baud16_en),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_error  (rx_error),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Transmitter and register-bus environment
    logic       model_busy = 1'b0;
    logic       hold_busy = 1'b0;
    logic       suppress_rise = 1'b0;
    logic       start_seen = 1'b0;
    int         busy_left = 0;
    assign tx_busy = model_busy | hold_busy;

    logic [7:0] slave_mem [16];
    logic       rd_stage = 1'b0;
    logic [3:0] rd_addr = 4'h0;
    int         tx_cnt = 0, wr_cnt = 0, rd_cnt = 0;
    logic [7:0] last_tx = 8'h00;
    logic [3:0] last_wr_addr = 4'h0;
    logic [7:0] last_wr_data = 8'h00;

    initial for (int i = 0; i < 16; i++) slave_mem[i] = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            rd_stage = 1'b0;
        end else begin
            if (tx_start) begin
                tx_cnt++;
                last_tx    = tx_data;
                start_seen = 1'b1;
                check("tx_start while tx_busy", tx_busy, 1'b0);
            end
            if (reg_wr || reg_rd) check("reg_wr and reg_rd together", reg_wr & reg_rd, 1'b0);
            if (reg_wr) begin
                wr_cnt++;
                last_wr_addr = reg_addr;
                last_wr_data = reg_wdata;
                slave_mem[reg_addr] = reg_wdata;
            end
            // Read data is valid only in the cycle after reg_rd; garbage otherwise.
            if (rd_stage) begin
                reg_rdata = slave_mem[rd_addr];
                rd_stage  = 1'b0;
            end else begin
                reg_rdata = 8'($urandom);
            end
            if (reg_rd) begin
                rd_cnt++;
                rd_stage = 1'b1;
                rd_addr  = reg_addr;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            model_busy = 1'b0;
            start_seen = 1'b0;
        end else if (start_seen && !suppress_rise) begin
            start_seen = 1'b0;
            model_busy = 1'b1;
            busy_left  = $urandom_range(3, 12);
        end else if (model_busy) begin
            if (busy_left == 0) model_busy = 1'b0;
            else busy_left--;
        end
    end

    // Frame-level reference model
    logic [7:0] exp_mem [NUM_REGS];
    int         exp_err = 0;
    logic [7:0] exp_reply;
    bit         exp_wr, exp_rd;
    logic [7:0] exp_wr_addr, exp_wr_data;
    int         exp_n;
    logic [7:0] fb [3];
    bit         fe [3];
    int         snap_tx, snap_wr, snap_rd;

    initial for (int i = 0; i < NUM_REGS; i++) exp_mem[i] = 8'h00;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic tick();
        baud16_en = 1'b1;
        step();
        baud16_en = 1'b0;
        step();
    endtask

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic model_frame(input logic [7:0] b0, b1, b2, input bit e0, e1, e2);
        bit nak = 1'b0;
        fb[0] = b0; fb[1] = b1; fb[2] = b2;
        fe[0] = e0; fe[1] = e1; fe[2] = e2;
        exp_wr = 1'b0; exp_rd = 1'b0; exp_wr_addr = 8'h00; exp_wr_data = 8'h00;
        if (e0 || (b0 != 8'h57 && b0 != 8'h52)) begin
            exp_n = 1; nak = 1'b1;
        end else if (e1 || b1 >= NUM_REGS) begin
            exp_n = 2; nak = 1'b1;
        end else if (b0 == 8'h52) begin
            exp_n = 2; exp_reply = exp_mem[b1]; exp_rd = 1'b1;
        end else if (e2) begin
            exp_n = 3; nak = 1'b1;
        end else begin
            exp_n = 3; exp_mem[b1] = b2; exp_reply = ACK;
            exp_wr = 1'b1; exp_wr_addr = b1; exp_wr_data = b2;
        end
        if (nak) begin
            exp_reply = NAK;
            bump_err();
        end
        snap_tx = tx_cnt; snap_wr = wr_cnt; snap_rd = rd_cnt;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit e);
        rx_data  = b;
        rx_error = e;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'($urandom);
        repeat ($urandom_range(0, 3)) step();
    endtask

    task automatic send_frame();
        for (int i = 0; i < exp_n; i++) send_byte(fb[i], fe[i]);
    endtask

    task automatic finish_frame(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (tx_cnt != snap_tx && !busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check({tag, " completed"}, done, 1'b1);
        check({tag, " tx_start count"}, tx_cnt - snap_tx, 1);
        check({tag, " reply byte"}, last_tx, exp_reply);
        check({tag, " err_count"}, err_count, exp_err);
        check({tag, " reg_wr count"}, wr_cnt - snap_wr, exp_wr);
        check({tag, " reg_rd count"}, rd_cnt - snap_rd, exp_rd);
        if (exp_wr) begin
            check({tag, " write addr"}, last_wr_addr, exp_wr_addr);
            check({tag, " write data"}, last_wr_data, exp_wr_data);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b0, b1, b2,
                             input bit e0, e1, e2);
        model_frame(b0, b1, b2, e0, e1, e2);
        send_frame();
        finish_frame(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] rb0, rb1, rb2;
    bit         re0, re1, re2, seen;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset busy", busy, 1'b0);
        check("reset tx_start", tx_start, 1'b0);
        check("reset tx_data", tx_data, 8'h00);
        check("reset err_count", err_count, 8'h00);
        check("reset reg_wr", reg_wr, 1'b0);
        check("reset reg_rd", reg_rd, 1'b0);
        rst = 1'b0;
        step();

        run_frame("write 3", 8'h57, 8'h03, 8'hA5, 0, 0, 0);
        run_frame("read 3", 8'h52, 8'h03, 8'h00, 0, 0, 0);
        run_frame("read addr 0C", 8'h52, 8'h0C, 8'h00, 0, 0, 0);
        run_frame("write addr FF", 8'h57, 8'hFF, 8'h00, 0, 0, 0);
        run_frame("last valid addr", 8'h57, 8'h0B, 8'h5A, 0, 0, 0);
        run_frame("bad data byte", 8'h57, 8'h01, 8'h3C, 0, 0, 1);
        run_frame("addr rx_error", 8'h52, 8'h02, 8'h00, 0, 1, 0);
        run_frame("cmd rx_error", 8'h57, 8'h00, 8'h00, 1, 0, 0);
        run_frame("unknown cmd", 8'h41, 8'h00, 8'h00, 0, 0, 0);

        // Frame dropped on the 640th tick with no reply
        snap_tx = tx_cnt;
        send_byte(8'h57, 0);
        repeat (TIMEOUT_TICKS - 1) tick();
        check("timeout busy before last tick", busy, 1'b1);
        tick();
        check("timeout busy after last tick", busy, 1'b0);
        bump_err();
        repeat (30) step();
        check("timeout no reply", tx_cnt - snap_tx, 0);
        check("timeout err_count", err_count, exp_err);
        run_frame("read after timeout", 8'h52, 8'h00, 8'h00, 0, 0, 0);

        // Byte arriving together with the expiry tick is accepted
        model_frame(8'h57, 8'h03, 8'h77, 0, 0, 0);
        send_byte(8'h57, 0);
        repeat (TIMEOUT_TICKS - 1) tick();
        rx_data = 8'h03; rx_ready = 1'b1; baud16_en = 1'b1;
        step();
        rx_ready = 1'b0; baud16_en = 1'b0;
        check("byte beats timeout busy", busy, 1'b1);
        send_byte(8'h77, 0);
        finish_frame("byte beats timeout");

        // Transmitter busy before the reply is ready
        hold_busy = 1'b1;
        model_frame(8'h57, 8'h07, 8'hC3, 0, 0, 0);
        send_frame();
        repeat (20) step();
        check("held tx no start", tx_cnt - snap_tx, 0);
        check("held tx busy", busy, 1'b1);
        hold_busy = 1'b0;
        finish_frame("held tx");

        // Byte during WAIT_LO is discarded
        model_frame(8'h52, 8'h07, 8'h00, 0, 0, 0);
        send_frame();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (model_busy) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("inject tx busy seen", seen, 1'b1);
        step();
        send_byte(8'h57, 0);
        finish_frame("inject in wait_lo");
        repeat (5) step();
        check("inject ignored busy", busy, 1'b0);

        for (int n = 0; n < 60; n++) begin
            rb0 = ($urandom_range(0, 9) != 0) ? (($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52)
                                             : 8'($urandom);
            rb1 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, NUM_REGS - 1));
            rb2 = 8'($urandom);
            re0 = ($urandom_range(0, 19) == 0);
            re1 = ($urandom_range(0, 19) == 0);
            re2 = ($urandom_range(0, 19) == 0);
            run_frame("random", rb0, rb1, rb2, re0, re1, re2);
        end

        for (int n = 0; n < 260; n++) run_frame("saturate", 8'h41, 8'h00, 8'h00, 0, 0, 0);
        check("err_count saturated", err_count, 8'hFF);

        // Reset while waiting for the transmitter to go busy
        suppress_rise = 1'b1;
        model_frame(8'h57, 8'h05, 8'h33, 0, 0, 0);
        send_frame();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_cnt != snap_tx) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("pre-reset tx_start seen", seen, 1'b1);
        check("pre-reset write done", wr_cnt - snap_wr, 1);
        step();
        step();
        check("pre-reset busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid reset busy", busy, 1'b0);
        check("mid reset tx_data", tx_data, 8'h00);
        check("mid reset err_count", err_count, 8'h00);
        check("mid reset tx_start", tx_start, 1'b0);
        check("mid reset reg_addr", reg_addr, 4'h0);
        step();
        step();
        rst = 1'b0;
        suppress_rise = 1'b0;
        exp_err = 0;
        step();
        run_frame("read after reset", 8'h52, 8'h05, 8'h00, 0, 0, 0);
        run_frame("write after reset", 8'h57, 8'h0A, 8'h9E, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
